// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: PC-sequential fetch over req/ack into a DEPTH-entry FIFO of {instr, pc+1}.
// Latency: ack at edge N gives valid from N+1; a redirect at an idle/ack edge issues the new PC at that edge.
// Backpressure: consume low holds the head; a fetch is issued only when a queue slot is free for its return.
module fetch_prefetch_queue #(
    parameter int ADDRESS_LEN     = 12,
    parameter int INSTRUCTION_LEN = 19,
    parameter int DEPTH           = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect,
    input  logic [ADDRESS_LEN-1:0]     redirect_pc,
    input  logic                       consume,
    output logic                       valid,
    output logic [INSTRUCTION_LEN-1:0] instruction,
    output logic [ADDRESS_LEN-1:0]     pc_plus1,
    output logic                       imem_req,
    output logic [ADDRESS_LEN-1:0]     imem_addr,
    input  logic                       imem_ack,
    input  logic [INSTRUCTION_LEN-1:0] imem_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [INSTRUCTION_LEN-1:0] instr;
        logic [ADDRESS_LEN-1:0]     pc1;
    } entry_t;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                 state;
    entry_t                 queue [DEPTH];
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       count_after;
    logic [ADDRESS_LEN-1:0] fetch_pc;
    logic                   drop;
    logic                   head_vld;
    logic                   push;
    logic                   pop;
    logic                   space;

    // Redirect suppresses both queue ports; data returned for a dropped request never lands.
    always_comb begin
        head_vld    = (count != '0);
        push        = (state == WAIT) && imem_ack && !drop && !redirect;
        pop         = consume && head_vld && !redirect;
        count_after = count + CNT_W'(push) - CNT_W'(pop);
        space       = (count_after < CNT_W'(DEPTH));
    end

    always_comb begin
        valid       = head_vld;
        instruction = '0;
        pc_plus1    = '0;
        if (head_vld) begin
            instruction = queue[rd_ptr].instr;
            pc_plus1    = queue[rd_ptr].pc1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            queue[wr_ptr] <= '{instr: imem_data, pc1: imem_addr + ADDRESS_LEN'(1)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            fetch_pc  <= '0;
            drop      <= 1'b0;
            imem_req  <= 1'b0;
            imem_addr <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            if (state == WAIT && !imem_ack) begin
                // Request still in flight: keep the handshake stable and discard its data later.
                drop     <= 1'b1;
                fetch_pc <= redirect_pc;
            end else begin
                drop      <= 1'b0;
                state     <= WAIT;
                imem_req  <= 1'b1;
                imem_addr <= redirect_pc;
                fetch_pc  <= redirect_pc + ADDRESS_LEN'(1);
            end
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_after;
            case (state)
                IDLE: begin
                    if (count < CNT_W'(DEPTH)) begin
                        state     <= WAIT;
                        imem_req  <= 1'b1;
                        imem_addr <= fetch_pc;
                        fetch_pc  <= fetch_pc + ADDRESS_LEN'(1);
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        drop <= 1'b0;
                        if (space) begin
                            imem_req  <= 1'b1;
                            imem_addr <= fetch_pc;
                            fetch_pc  <= fetch_pc + ADDRESS_LEN'(1);
                        end else begin
                            state    <= IDLE;
                            imem_req <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fetch_prefetch_queue.md
# fetch_prefetch_queue

Instruction-fetch front end feeding the IF/ID pipeline register. Drives PC-sequential requests to a multi-cycle instruction memory over a req/ack handshake and buffers returned instructions, tagged with PC+1, in a small FIFO. It presents the head entry to IF/ID and honours stall (consume low) and redirect (branch, jump or return flush) from the decode and execute stages.

## Interface
Parameters:
- ADDRESS_LEN, default 12: PC / instruction address width.
- INSTRUCTION_LEN, default 19: instruction word width.
- DEPTH, default 4: queue entries; power of two, minimum 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- redirect  in  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  in  ADDRESS_LEN  new fetch address (next_pc from the PC mux).
- consume  in  1  IF/ID captures the head this cycle (IF/ID write enable and not stalled).
- valid  out  1  head entry present.
- instruction  out  INSTRUCTION_LEN  head instruction; all-zero when valid=0.
- pc_plus1  out  ADDRESS_LEN  head entry's PC+1; zero when valid=0.
- imem_req  out  1  fetch request, registered.
- imem_addr  out  ADDRESS_LEN  fetch address, registered, stable while imem_req=1.
- imem_ack  in  1  memory response; imem_data valid this cycle.
- imem_data  in  INSTRUCTION_LEN  fetched instruction.

## Operation
- State: fetch_pc, queue storage (DEPTH × {instruction, pc_plus1}), rd/wr pointers, count (0..DEPTH), outstanding flag, drop flag.
- Reset: fetch_pc=0, count=0, pointers=0, outstanding=0, drop=0, imem_req=0, imem_addr=0, valid=0, instruction=0, pc_plus1=0.
- Request FSM, states IDLE and WAIT:
  - IDLE→WAIT when count + (pending pushes) < DEPTH and not rst: imem_req<=1, imem_addr<=fetch_pc, fetch_pc<=fetch_pc+1 (mod 2^ADDRESS_LEN).
  - WAIT: hold imem_req and imem_addr until imem_ack=1. On ack: if drop=0, push {imem_data, imem_addr+1}; if drop=1, discard and clear drop. Then issue the next request in the same edge if space remains after this push and any consume (stay WAIT with a new address); otherwise go to IDLE.
- At most one outstanding request. A slot is never allocated beyond DEPTH, so the queue cannot overflow.
- Pop: consume=1 and valid=1 advances rd pointer. consume with valid=0 is ignored.
- Push and pop in the same cycle: count unchanged, both pointers advance. Legal when full, since the slot is freed by the same-edge pop.
- Redirect, highest priority after rst:
  - count<=0, pointers<=0, fetch_pc<=redirect_pc.
  - Same-cycle push or consume is suppressed.
  - If a request is in WAIT without ack this cycle: keep req/addr held, set drop=1; the next request (redirect_pc) is issued the cycle after that ack.
  - If ack arrives in the redirect cycle: discard the data; the FSM issues redirect_pc next edge.
  - In IDLE: issue redirect_pc on the next edge.
- Redirect while drop=1: drop stays 1 and fetch_pc takes the latest redirect_pc.
- Pointers wrap modulo DEPTH. fetch_pc and pc_plus1 wrap 0xFFF→0x000.

## Timing
- imem_req first asserts in the cycle after the rst deassert edge, with imem_addr=0.
- Zero-wait memory (ack in the request cycle): one push per cycle. Steady state is 1 instruction/cycle when consume=1 continuously.
- Ack at edge N makes valid=1 from cycle N+1. Fetch-to-issue latency is 1 cycle minimum.
- Redirect at edge N (IDLE or ack at N): imem_addr=redirect_pc from N+1. The first redirected instruction is valid at N+2 with zero-wait memory.
- Outputs valid, instruction and pc_plus1 depend only on registered state; there are no combinational paths from inputs.
- rst mid-transaction: FSM to IDLE and all state cleared. A late ack after reset, with imem_req=0, is ignored.

## Test plan
- Reset then zero-wait memory returning data=addr, consume held 1: imem_addr 0,1,2,3…; valid from cycle 2; instruction 0,1,2…; pc_plus1 1,2,3… consecutively.
- consume=0 with zero-wait memory: exactly 4 requests issued (addr 0–3) and imem_req drops. Raising consume resumes at addr 4 with no loss or duplication.
- 3-cycle memory latency: imem_addr held for 3 cycles per request; one instruction every 3 cycles; queue never exceeds one entry while consumed.
- Redirect to 0x200 while a request for 0x005 is pending with 2-cycle latency: the 0x005 data is dropped; the next imem_addr is 0x200; the first valid head has pc_plus1=0x201; the queue is empty in between.
- Redirect to 0xFFF with zero-wait memory: fetch sequence 0xFFF,0x000; pc_plus1 0x000,0x001.
- Redirect in the same cycle as a full-queue consume+ack: the queue empties, no entry survives, and valid=0 on the next cycle.
